// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode plus iterative multiply/divide unit.
// HI/LO registers, shift-add multiply and restoring divide, 1 bit/edge.
module alu_ctrl_mdu #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [1:0]       aluop_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [2:0]       alucont_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] mdu_rdata_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_bzero;

    logic             w_rtype;
    logic             w_is_mul;
    logic             w_is_dv;
    logic             w_is_mf;
    logic             w_start;
    logic             w_sgn_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_ph_n;
    logic [WIDTH-1:0] w_pl_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_hi_fin;
    logic [WIDTH-1:0] w_lo_fin;

    assign w_rtype  = (aluop_i == 2'b10);
    assign w_is_mul = (funct_i == F_MULT) || (funct_i == F_MULTU);
    assign w_is_dv  = DIV_EN && ((funct_i == F_DIV) || (funct_i == F_DIVU));
    assign w_is_mf  = (funct_i == F_MFHI) || (funct_i == F_MFLO);
    assign w_start  = valid_i && w_rtype && (w_is_mul || w_is_dv) &&
                      ((r_state == S_IDLE) || (r_state == S_DONE)) && !flush_i;
    assign stall_o  = valid_i && w_rtype && (r_state == S_RUN) &&
                      (w_is_mul || w_is_dv || w_is_mf);
    assign done_o   = (r_state == S_DONE);
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

    // Signed ops iterate on magnitudes; signs are restored at the last edge
    assign w_sgn_op = (funct_i == F_MULT) || (funct_i == F_DIV);
    assign w_a_neg  = w_sgn_op && a_i[WIDTH-1];
    assign w_b_neg  = w_sgn_op && b_i[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a_i : a_i;
    assign w_b_mag  = w_b_neg ? -b_i : b_i;

    // ALU control code decode
    always_comb begin
        alucont_o = 3'b101;
        unique case (aluop_i)
            2'b00: alucont_o = 3'b010;
            2'b01: alucont_o = 3'b110;
            2'b11: alucont_o = 3'b100;
            2'b10: begin
                case (funct_i)
                    6'b100000: alucont_o = 3'b010;
                    6'b100010: alucont_o = 3'b110;
                    6'b100100: alucont_o = 3'b000;
                    6'b100101: alucont_o = 3'b001;
                    6'b101010: alucont_o = 3'b111;
                    6'b001000: alucont_o = 3'b011;
                    default:   alucont_o = 3'b101;
                endcase
            end
        endcase
    end

    // HI/LO read mux for mfhi/mflo
    always_comb begin
        mdu_rdata_o = '0;
        if (w_rtype && funct_i == F_MFHI) begin
            mdu_rdata_o = r_hi;
        end else if (w_rtype && funct_i == F_MFLO) begin
            mdu_rdata_o = r_lo;
        end
    end

    // One iteration step of multiply or divide, plus final sign fix-up
    always_comb begin
        w_sum  = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : '0);
        w_t    = {r_ph, r_pl[WIDTH-1]};
        w_ge   = (w_t >= {1'b0, r_b});
        w_diff = w_t[WIDTH-1:0] - r_b;
        if (r_is_div) begin
            w_ph_n = w_ge ? w_diff : w_t[WIDTH-1:0];
            w_pl_n = {r_pl[WIDTH-2:0], w_ge};
        end else begin
            w_ph_n = w_sum[WIDTH:1];
            w_pl_n = {w_sum[0], r_pl[WIDTH-1:1]};
        end
        w_prod = r_neg_q ? -{w_ph_n, w_pl_n} : {w_ph_n, w_pl_n};
        if (!r_is_div) begin
            w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
            w_lo_fin = w_prod[WIDTH-1:0];
        end else if (r_bzero) begin
            w_hi_fin = r_a_raw;
            w_lo_fin = '1;
        end else begin
            w_hi_fin = r_neg_r ? -w_ph_n : w_ph_n;
            w_lo_fin = r_neg_q ? -w_pl_n : w_pl_n;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        w_state_n = r_state;
        if (flush_i) begin
            w_state_n = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_start) w_state_n = S_RUN;
                S_RUN:   if (r_cnt == '0) w_state_n = S_DONE;
                S_DONE:  w_state_n = w_start ? S_RUN : S_IDLE;
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= CNT_MAX;
            r_ph     <= '0;
            r_is_div <= w_is_dv;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_bzero  <= (b_i == '0);
            r_a_raw  <= a_i;
            r_pl     <= w_is_dv ? w_a_mag : w_b_mag;
            r_b      <= w_is_dv ? w_b_mag : w_a_mag;
        end else if (r_state == S_RUN && !flush_i) begin
            r_ph  <= w_ph_n;
            r_pl  <= w_pl_n;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_hi <= w_hi_fin;
                r_lo <= w_lo_fin;
            end
        end
    end

endmodule
